pcie_rq_arbiter: RTL and testbench



---
 rtl/pcie_rq_arbiter.sv | 137 +++++++++++++
 tb/tb_pcie_rq_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_rq_arbiter.sv
// Packet-level 2:1 arbiter for the PCIe RQ stream: ATS invalidation completions vs. user requests.
// Optional packet/stall counters are compiled in with the RQ_ARB_STATS_EN macro.
module pcie_rq_arbiter #(
    parameter int AXIS_DATA_WIDTH = 512,
    parameter int RQ_AXIS_TUSER_W = 183,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [AXIS_DATA_WIDTH-1:0]   s_usr_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0] s_usr_tkeep,
    input  logic [RQ_AXIS_TUSER_W-1:0]   s_usr_tuser,
    input  logic                         s_usr_tvalid,
    input  logic                         s_usr_tlast,
    output logic                         s_usr_tready,
    input  logic [AXIS_DATA_WIDTH-1:0]   s_ats_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0] s_ats_tkeep,
    input  logic [RQ_AXIS_TUSER_W-1:0]   s_ats_tuser,
    input  logic                         s_ats_tvalid,
    input  logic                         s_ats_tlast,
    output logic                         s_ats_tready,
    output logic [AXIS_DATA_WIDTH-1:0]   m_axis_rq_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_rq_tkeep,
    output logic [RQ_AXIS_TUSER_W-1:0]   m_axis_rq_tuser,
    output logic                         m_axis_rq_tvalid,
    output logic                         m_axis_rq_tlast,
    input  logic                         m_axis_rq_tready,
    output logic                         grant_usr,
    output logic                         grant_ats
`ifdef RQ_ARB_STATS_EN
    ,
    output logic [31:0]                  usr_pkt_cnt,
    output logic [31:0]                  ats_pkt_cnt,
    output logic [31:0]                  stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_USR = 2'd1,
        GNT_ATS = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state_q, state_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        starve_cnt_d     = starve_cnt_q;
        s_usr_tready     = 1'b0;
        s_ats_tready     = 1'b0;
        m_axis_rq_tdata  = '0;
        m_axis_rq_tkeep  = '0;
        m_axis_rq_tuser  = '0;
        m_axis_rq_tvalid = 1'b0;
        m_axis_rq_tlast  = 1'b0;
        grant_usr        = 1'b0;
        grant_ats        = 1'b0;
        case (state_q)
            IDLE: begin
                // ATS wins unless the user has already waited through LIMIT ATS grants
                if (s_ats_tvalid && (!s_usr_tvalid || (starve_cnt_q < LIMIT))) begin
                    state_d = GNT_ATS;
                    if (s_usr_tvalid && (starve_cnt_q != 4'hF)) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end else if (s_usr_tvalid) begin
                    state_d      = GNT_USR;
                    starve_cnt_d = 4'd0;
                end
            end
            GNT_USR: begin
                m_axis_rq_tdata  = s_usr_tdata;
                m_axis_rq_tkeep  = s_usr_tkeep;
                m_axis_rq_tuser  = s_usr_tuser;
                m_axis_rq_tvalid = s_usr_tvalid;
                m_axis_rq_tlast  = s_usr_tlast;
                s_usr_tready     = m_axis_rq_tready;
                grant_usr        = 1'b1;
                if (s_usr_tvalid && m_axis_rq_tready && s_usr_tlast) begin
                    state_d = IDLE;
                end
            end
            GNT_ATS: begin
                m_axis_rq_tdata  = s_ats_tdata;
                m_axis_rq_tkeep  = s_ats_tkeep;
                m_axis_rq_tuser  = s_ats_tuser;
                m_axis_rq_tvalid = s_ats_tvalid;
                m_axis_rq_tlast  = s_ats_tlast;
                s_ats_tready     = m_axis_rq_tready;
                grant_ats        = 1'b1;
                if (s_ats_tvalid && m_axis_rq_tready && s_ats_tlast) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef RQ_ARB_STATS_EN
    logic [31:0] usr_pkt_cnt_q, ats_pkt_cnt_q, stall_cnt_q;
    logic        last_hs;

    assign last_hs = m_axis_rq_tvalid && m_axis_rq_tready && m_axis_rq_tlast;

    always_ff @(posedge clk) begin
        if (rst) begin
            usr_pkt_cnt_q <= 32'd0;
            ats_pkt_cnt_q <= 32'd0;
            stall_cnt_q   <= 32'd0;
        end else begin
            if (last_hs && grant_usr) usr_pkt_cnt_q <= usr_pkt_cnt_q + 32'd1;
            if (last_hs && grant_ats) ats_pkt_cnt_q <= ats_pkt_cnt_q + 32'd1;
            if (m_axis_rq_tvalid && !m_axis_rq_tready) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign usr_pkt_cnt = usr_pkt_cnt_q;
    assign ats_pkt_cnt = ats_pkt_cnt_q;
    assign stall_cnt   = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pcie_rq_arbiter.sv
// Self-checking bench for pcie_rq_arbiter: scoreboard on the RQ master side plus table-driven grant checks.
module tb_pcie_rq_arbiter;

    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam int UW = 183;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] usr_tdata = '0, ats_tdata = '0;
    logic [KW-1:0] usr_tkeep = '0, ats_tkeep = '0;
    logic [UW-1:0] usr_tuser = '0, ats_tuser = '0;
    logic          usr_v = 1'b0, usr_tlast = 1'b0, ats_v = 1'b0, ats_tlast = 1'b0;
    logic          usr_tready, ats_tready;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic [UW-1:0] m_tuser;
    logic          m_tvalid, m_tlast, m_ready = 1'b0;
    logic          grant_usr, grant_ats;

    // second instance with STARVE_LIMIT=0, own valids
    logic          z_uv = 1'b0, z_av = 1'b0;
    logic          z_ur, z_ar, z_mv, z_ml, z_gu, z_ga;
    logic [DW-1:0] z_md;
    logic [KW-1:0] z_mk;
    logic [UW-1:0] z_mu;

`ifdef RQ_ARB_STATS_EN
    logic [31:0] usr_pkt_cnt, ats_pkt_cnt, stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic          src;   // 1 = user, 0 = ATS
        logic [DW-1:0] data;
        logic          last;
    } beat_t;
    beat_t sb[$];

    typedef struct packed {
        logic       uv;
        logic       av;
        logic [4:0] exp;  // {grant_usr, grant_ats, usr_tready, ats_tready, m_tvalid}
    } vec_t;

    always #5 clk = ~clk;

    pcie_rq_arbiter #(.AXIS_DATA_WIDTH(DW), .RQ_AXIS_TUSER_W(UW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .s_usr_tdata(usr_tdata), .s_usr_tkeep(usr_tkeep), .s_usr_tuser(usr_tuser),
        .s_usr_tvalid(usr_v), .s_usr_tlast(usr_tlast), .s_usr_tready(usr_tready),
        .s_ats_tdata(ats_tdata), .s_ats_tkeep(ats_tkeep), .s_ats_tuser(ats_tuser),
        .s_ats_tvalid(ats_v), .s_ats_tlast(ats_tlast), .s_ats_tready(ats_tready),
        .m_axis_rq_tdata(m_tdata), .m_axis_rq_tkeep(m_tkeep), .m_axis_rq_tuser(m_tuser),
        .m_axis_rq_tvalid(m_tvalid), .m_axis_rq_tlast(m_tlast), .m_axis_rq_tready(m_ready),
        .grant_usr(grant_usr), .grant_ats(grant_ats)
`ifdef RQ_ARB_STATS_EN
        , .usr_pkt_cnt(usr_pkt_cnt), .ats_pkt_cnt(ats_pkt_cnt), .stall_cnt(stall_cnt)
`endif
    );

    pcie_rq_arbiter #(.AXIS_DATA_WIDTH(DW), .RQ_AXIS_TUSER_W(UW), .STARVE_LIMIT(0)) dut_z (
        .clk(clk), .rst(rst),
        .s_usr_tdata(usr_tdata), .s_usr_tkeep(usr_tkeep), .s_usr_tuser(usr_tuser),
        .s_usr_tvalid(z_uv), .s_usr_tlast(1'b1), .s_usr_tready(z_ur),
        .s_ats_tdata(ats_tdata), .s_ats_tkeep(ats_tkeep), .s_ats_tuser(ats_tuser),
        .s_ats_tvalid(z_av), .s_ats_tlast(1'b1), .s_ats_tready(z_ar),
        .m_axis_rq_tdata(z_md), .m_axis_rq_tkeep(z_mk), .m_axis_rq_tuser(z_mu),
        .m_axis_rq_tvalid(z_mv), .m_axis_rq_tlast(z_ml), .m_axis_rq_tready(1'b1),
        .grant_usr(z_gu), .grant_ats(z_ga)
`ifdef RQ_ARB_STATS_EN
        , .usr_pkt_cnt(), .ats_pkt_cnt(), .stall_cnt()
`endif
    );

    // Scoreboard: every master-side handshake must match the next expected beat.
    always @(negedge clk) begin
        if (m_tvalid && m_ready) begin
            beat_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got data=%0h last=%0b gu=%0b, required no beat",
                         m_tdata[31:0], m_tlast, grant_usr);
            end else begin
                e = sb.pop_front();
                if (e.data !== m_tdata || e.last !== m_tlast ||
                    {grant_usr, grant_ats} !== {e.src, !e.src}) begin
                    errors++;
                    $display("FAIL sb_beat: got data=%0h last=%0b grant=%b%b, required data=%0h last=%0b src_usr=%0b",
                             m_tdata[31:0], m_tlast, grant_usr, grant_ats, e.data[31:0], e.last, e.src);
                end else begin
                    $display("beat ok: src_usr=%0b data=%0h last=%0b", e.src, e.data[31:0], e.last);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        usr_v = 1'b0;
        ats_v = 1'b0;
        z_uv  = 1'b0;
        z_av  = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Single-beat TLP; m_ready held low for the IDLE cycle plus st grant cycles.
    task automatic send(input logic src, input logic [DW-1:0] d, input int st);
        logic done;
        done = 1'b0;
        sb.push_back('{src: src, data: d, last: 1'b1});
        if (src) begin usr_v = 1'b1; usr_tdata = d; usr_tlast = 1'b1; end
        else     begin ats_v = 1'b1; ats_tdata = d; ats_tlast = 1'b1; end
        for (int c = 0; c < st + 10 && !done; c++) begin
            m_ready = (c > st);
            @(negedge clk);
            done = src ? (usr_v && usr_tready) : (ats_v && ats_tready);
            step();
        end
        if (src) usr_v = 1'b0; else ats_v = 1'b0;
        m_ready = 1'b1;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout: got no handshake, required one (src_usr=%0b)", src);
        end
    endtask

    initial begin
        vec_t          tbl[14];
        vec_t          ztbl[7];
        logic [DW-1:0] d;
        logic [UW-1:0] u;
        int            b;
        logic          tog;

        // reset state
        do_reset();
        rst = 1'b1;
        usr_v = 1'b1;
        ats_v = 1'b1;
        @(negedge clk);
        chk("rst_outputs", {grant_usr, grant_ats, usr_tready, ats_tready, m_tvalid, m_tlast}, 0);
        chk("rst_mdata", m_tdata, 0);
        step();
        usr_v = 1'b0;
        ats_v = 1'b0;
        rst = 1'b0;
        step();

        // single-beat ATS TLP, bit-exact pass-through
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        for (int i = 0; i < UW; i++) u[i] = 1'($urandom_range(1));
        ats_tdata = d; ats_tkeep = 64'hFFFF; ats_tuser = u; ats_tlast = 1'b1;
        ats_v = 1'b1; m_ready = 1'b1;
        sb.push_back('{src: 1'b0, data: d, last: 1'b1});
        @(negedge clk);
        chk("t1_idle_grant", {grant_ats, m_tvalid}, 0);
        step();
        @(negedge clk);
        chk("t1_grant_ats", {grant_usr, grant_ats, ats_tready}, 3'b011);
        chk("t1_tdata", m_tdata, d);
        chk("t1_tkeep", m_tkeep, 64'hFFFF);
        chk("t1_tuser", m_tuser, u);
        step();
        ats_v = 1'b0;
        @(negedge clk);
        chk("t1_back_idle", {grant_usr, grant_ats, m_tvalid}, 0);
        step();

        // 4-beat user TLP with toggling m_ready; ATS arrives mid-packet and waits
        for (int i = 0; i < 4; i++)
            sb.push_back('{src: 1'b1, data: DW'(32'h2000 + i), last: (i == 3)});
        sb.push_back('{src: 1'b0, data: DW'(32'h2A00), last: 1'b1});
        b = 0; tog = 1'b1; usr_v = 1'b1; usr_tkeep = '1;
        for (int c = 0; c < 40 && b < 4; c++) begin
            usr_tdata = DW'(32'h2000 + b);
            usr_tlast = (b == 3);
            m_ready = tog;
            tog = !tog;
            if (b >= 1) begin ats_v = 1'b1; ats_tdata = DW'(32'h2A00); ats_tlast = 1'b1; end
            @(negedge clk);
            if (ats_v) chk("t2_ats_stalled", ats_tready, 0);
            if (usr_v && usr_tready) b++;
            step();
        end
        usr_v = 1'b0;
        chk("t2_user_beats", b, 4);
        m_ready = 1'b1;
        b = 0;
        for (int c = 0; c < 10 && b == 0; c++) begin
            @(negedge clk);
            if (ats_v && ats_tready) b = 1;
            step();
        end
        ats_v = 1'b0;
        chk("t2_ats_granted_after", b, 1);

        // starvation guard, STARVE_LIMIT=4: ATS x4 then USR
        do_reset();
        for (int i = 0; i < 14; i++) tbl[i] = '{uv: 1'b1, av: 1'b1, exp: 5'b00000};
        tbl[1].exp = 5'b01011; tbl[3].exp = 5'b01011; tbl[5].exp = 5'b01011;
        tbl[7].exp = 5'b01011; tbl[9].exp = 5'b10101; tbl[11].exp = 5'b01011;
        tbl[13].exp = 5'b01011;
        usr_tlast = 1'b1; ats_tlast = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            usr_v = tbl[i].uv; ats_v = tbl[i].av;
            usr_tdata = DW'(32'h3000 + i); ats_tdata = DW'(32'h3A00 + i);
            if (tbl[i].exp[0])
                sb.push_back('{src: tbl[i].exp[4], data: tbl[i].exp[4] ? usr_tdata : ats_tdata, last: 1'b1});
            @(negedge clk);
            chk($sformatf("starve_row%0d", i), {grant_usr, grant_ats, usr_tready, ats_tready, m_tvalid}, tbl[i].exp);
            step();
        end
        usr_v = 1'b0; ats_v = 1'b0;
        step();

        // STARVE_LIMIT=0 instance: user always wins while valid
        ztbl[0] = '{1'b1, 1'b1, 5'b00000}; ztbl[1] = '{1'b1, 1'b1, 5'b10000};
        ztbl[2] = '{1'b1, 1'b1, 5'b00000}; ztbl[3] = '{1'b1, 1'b1, 5'b10000};
        ztbl[4] = '{1'b0, 1'b1, 5'b00000}; ztbl[5] = '{1'b0, 1'b1, 5'b01000};
        ztbl[6] = '{1'b0, 1'b0, 5'b00000};
        for (int i = 0; i < 7; i++) begin
            z_uv = ztbl[i].uv; z_av = ztbl[i].av;
            @(negedge clk);
            chk($sformatf("nolimit_row%0d", i), {z_gu, z_ga}, ztbl[i].exp[4:3]);
            step();
        end
        z_uv = 1'b0; z_av = 1'b0;

        // reset during beat 2 of a 3-beat user TLP
        sb.push_back('{src: 1'b1, data: DW'(32'h5000), last: 1'b0});
        sb.push_back('{src: 1'b1, data: DW'(32'h5001), last: 1'b0});
        usr_v = 1'b1; usr_tlast = 1'b0; usr_tdata = DW'(32'h5000); m_ready = 1'b1;
        step();
        step();
        usr_tdata = DW'(32'h5001);
        rst = 1'b1;
        step();
        rst = 1'b0; usr_v = 1'b0;
        @(negedge clk);
        chk("t5_outputs_reset", {grant_usr, grant_ats, usr_tready, ats_tready, m_tvalid, m_tlast}, 0);
        chk("t5_mdata_reset", m_tdata, 0);
        chk("t5_mtuser_reset", m_tuser, 0);
        step();
        send(1'b0, DW'(32'h5A00), 0);

`ifdef RQ_ARB_STATS_EN
        do_reset();
        send(1'b1, DW'(32'h6000), 2);
        send(1'b1, DW'(32'h6001), 0);
        send(1'b1, DW'(32'h6002), 0);
        send(1'b0, DW'(32'h6A00), 3);
        send(1'b0, DW'(32'h6A01), 0);
        @(negedge clk);
        chk("stats_usr", usr_pkt_cnt, 3);
        chk("stats_ats", ats_pkt_cnt, 2);
        chk("stats_stall", stall_cnt, 5);
        step();
`endif

        step();
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
